mdp3_packet_tx: RTL and testbench

MDP3_PACKET_TX -- requirements
Module: mdp3_packet_tx

---
 rtl/mdp3_pkg.sv | 44 ++++
 rtl/mdp3_frame_pack.sv | 21 ++
 rtl/mdp3_packet_tx.sv | 133 +++++++++++++
 tb/tb_mdp3_packet_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mdp3_pkg.sv
// Shared constants, state encoding and message record for the MDP3 packet transmitter.
// Byte N of the 37-byte frame sits at bits [FRAME_W-1-8N -: 8] of the packed frame.
package mdp3_pkg;
  localparam int FRAME_BYTES = 37;
  localparam int BEATS       = 5;
  localparam int FRAME_W     = FRAME_BYTES * 8;

  localparam logic [103:0] FRAME_HDR = 104'h4D_44_50_33_00_25_01_02_03_04_05_06_07;

  localparam int OFF_ACTION = 13;
  localparam int OFF_ETYPE  = 14;
  localparam int OFF_SECID  = 15;
  localparam int OFF_SEQ    = 19;
  localparam int OFF_PRICE  = 23;
  localparam int OFF_QTY    = 31;
  localparam int OFF_NORD   = 33;
  localparam int OFF_LVL    = 34;
  localparam int OFF_PAD    = 35;

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA} state_e;

  typedef struct packed {
    logic [1:0]  action;
    logic [1:0]  entry_type;
    logic [31:0] security_id;
    logic [63:0] price;
    logic [15:0] quantity;
    logic [7:0]  num_orders;
    logic [7:0]  price_level;
  } msg_t;

  // Little-endian byte order: least significant byte goes out first.
  function automatic logic [15:0] le16(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction

  function automatic logic [31:0] le32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [63:0] le64(input logic [63:0] x);
    return {le32(x[31:0]), le32(x[63:32])};
  endfunction
endpackage

// File: rtl/mdp3_frame_pack.sv
// Combinational frame builder: held message record plus sequence number -> 37-byte frame.
module mdp3_frame_pack
  import mdp3_pkg::*;
(
  input  msg_t               msg,
  input  logic [31:0]        seq_num,
  output logic [FRAME_W-1:0] frame
);
  always_comb begin
    frame = {FRAME_HDR,
             6'd0, msg.action,
             6'd0, msg.entry_type,
             le32(msg.security_id),
             le32(seq_num),
             le64(msg.price),
             le16(msg.quantity),
             msg.num_orders,
             msg.price_level,
             16'h0000};
  end
endmodule

// File: rtl/mdp3_packet_tx.sv
// MDP3 packet transmitter: preamble beats then a 5-beat, 64-bit-wide frame per message.
// Optional sequence-number counter is built only when MDP3_TX_SEQNUM_EN is defined.
module mdp3_packet_tx
  import mdp3_pkg::*;
#(
  parameter int PREAMBLE_BEATS = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [1:0]  action,
  input  logic [1:0]  entry_type,
  input  logic [31:0] security_id,
  input  logic [63:0] price,
  input  logic [15:0] quantity,
  input  logic [7:0]  num_orders,
  input  logic [7:0]  price_level,
  input  logic        EN,
  output logic [63:0] data_out,
  output logic        start_packet,
  output logic        end_packet,
  output logic        busy
);
  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  msg_t               msg_q, msg_d, msg_in;
  logic [31:0]        seq_w;
  logic [FRAME_W-1:0] frame;
  logic [63:0]        beat;
  logic               last_beat;

  assign msg_in    = {action, entry_type, security_id, price, quantity, num_orders, price_level};
  assign last_beat = (state_q == ST_DATA) && (cnt_q == 4'(BEATS - 1));

`ifdef MDP3_TX_SEQNUM_EN
  logic [31:0] seq_num_q, seq_num_d;

  // Only a completed frame consumes a number; a reset-aborted frame does not.
  always_comb begin
    seq_num_d = seq_num_q;
    if (EN && last_beat) seq_num_d = seq_num_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) seq_num_q <= '0;
    else          seq_num_q <= seq_num_d;
  end

  assign seq_w = seq_num_q;
`else
  assign seq_w = '0;
`endif

  mdp3_frame_pack u_pack (
    .msg     (msg_q),
    .seq_num (seq_w),
    .frame   (frame)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    if (EN) begin
      case (state_q)
        ST_IDLE: if (msg_valid) begin
          msg_d   = msg_in;
          state_d = ST_PRE;
          cnt_d   = '0;
        end
        ST_PRE: begin
          if (cnt_q == 4'(PREAMBLE_BEATS - 1)) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_DATA: begin
          if (last_beat) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    case (cnt_q)
      4'd0:    beat = frame[FRAME_W-1   -: 64];
      4'd1:    beat = frame[FRAME_W-65  -: 64];
      4'd2:    beat = frame[FRAME_W-129 -: 64];
      4'd3:    beat = frame[FRAME_W-193 -: 64];
      default: beat = {frame[39:0], 24'h0};
    endcase
  end

  // Outputs are gated by reset_n so they drop in the reset cycle itself.
  always_comb begin
    msg_ready    = 1'b0;
    data_out     = '0;
    start_packet = 1'b0;
    end_packet   = 1'b0;
    busy         = 1'b0;
    if (reset_n) begin
      msg_ready    = EN && (state_q == ST_IDLE);
      busy         = (state_q != ST_IDLE);
      start_packet = (state_q == ST_PRE);
      end_packet   = last_beat;
      if (state_q == ST_DATA) data_out = beat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
    end
  end
endmodule

// File: tb/tb_mdp3_packet_tx.sv
// Randomized bench for mdp3_packet_tx with a byte-level frame model and cycle-exact beat checks.
module tb_mdp3_packet_tx;
  localparam int P = 6;

  typedef struct {
    logic [1:0]  action;
    logic [1:0]  entry_type;
    logic [31:0] security_id;
    logic [63:0] price;
    logic [15:0] quantity;
    logic [7:0]  num_orders;
    logic [7:0]  price_level;
  } tmsg_t;

  logic        clk = 1'b0;
  logic        reset_n, msg_valid, msg_ready, EN;
  logic [1:0]  action, entry_type;
  logic [31:0] security_id;
  logic [63:0] price;
  logic [15:0] quantity;
  logic [7:0]  num_orders, price_level;
  logic [63:0] data_out;
  logic        start_packet, end_packet, busy;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] exp_seq = '0;

  always #5 clk = ~clk;

  mdp3_packet_tx #(.PREAMBLE_BEATS(P)) dut (
    .clk(clk), .reset_n(reset_n), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .action(action), .entry_type(entry_type), .security_id(security_id), .price(price),
    .quantity(quantity), .num_orders(num_orders), .price_level(price_level), .EN(EN),
    .data_out(data_out), .start_packet(start_packet), .end_packet(end_packet), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference frame as a list of 37 bytes, laid out from the field table.
  function automatic logic [295:0] model_frame(input tmsg_t m, input logic [31:0] seq);
    logic [7:0]   b [37];
    logic [7:0]   hdr [13] = '{8'h4D, 8'h44, 8'h50, 8'h33, 8'h00, 8'h25, 8'h01,
                               8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    logic [295:0] f;
    for (int i = 0; i < 13; i++) b[i] = hdr[i];
    b[13] = {6'd0, m.action};
    b[14] = {6'd0, m.entry_type};
    for (int i = 0; i < 4; i++) b[15+i] = 8'(m.security_id >> (8*i));
    for (int i = 0; i < 4; i++) b[19+i] = 8'(seq >> (8*i));
    for (int i = 0; i < 8; i++) b[23+i] = 8'(m.price >> (8*i));
    for (int i = 0; i < 2; i++) b[31+i] = 8'(m.quantity >> (8*i));
    b[33] = m.num_orders;
    b[34] = m.price_level;
    b[35] = 8'h00;
    b[36] = 8'h00;
    f = '0;
    for (int i = 0; i < 37; i++) f = (f << 8) | 296'(b[i]);
    return f;
  endfunction

  function automatic logic [63:0] model_beat(input logic [295:0] f, input int k);
    logic [319:0] padded;
    padded = {f, 24'h0};
    return padded[319 - 64*k -: 64];
  endfunction

  function automatic tmsg_t rand_msg();
    tmsg_t m;
    m.action      = 2'($urandom);
    m.entry_type  = 2'($urandom);
    m.security_id = $urandom;
    m.price       = {$urandom, $urandom};
    m.quantity    = 16'($urandom);
    m.num_orders  = 8'($urandom);
    m.price_level = 8'($urandom);
    return m;
  endfunction

  task automatic drive_fields(input tmsg_t m);
    action = m.action; entry_type = m.entry_type; security_id = m.security_id;
    price = m.price; quantity = m.quantity; num_orders = m.num_orders;
    price_level = m.price_level;
  endtask

  task automatic expect_out(input string tag, input logic [63:0] d, input logic sp,
                            input logic ep, input logic bz, input logic rdy);
    @(negedge clk);
    chk({tag, ".data"},  data_out,     d);
    chk({tag, ".start"}, 64'(start_packet), 64'(sp));
    chk({tag, ".end"},   64'(end_packet),   64'(ep));
    chk({tag, ".busy"},  64'(busy),         64'(bz));
    chk({tag, ".ready"}, 64'(msg_ready),    64'(rdy));
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Offer m, then walk every beat; inputs toggle randomly after accept.
  task automatic run_frame(input tmsg_t m, input int stall_at, input int stall_len, input int rst_at);
    logic [295:0] f;
    logic [63:0]  d;
    logic [31:0]  seq_used;
`ifdef MDP3_TX_SEQNUM_EN
    seq_used = exp_seq;
`else
    seq_used = '0;
`endif
    drive_fields(m);
    msg_valid = 1'b1;
    EN = 1'b1;
    expect_out("accept", 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    f = model_frame(m, seq_used);
    next_cycle();
    drive_fields(rand_msg());
    for (int idx = 0; idx < P + 5; idx++) begin
      d = (idx < P) ? 64'h0 : model_beat(f, idx - P);
      if (idx == rst_at) begin
        reset_n = 1'b0;
        expect_out("abort", 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        reset_n = 1'b1;
        msg_valid = 1'b0;
        exp_seq = '0;
        return;
      end
      if (idx == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          EN = 1'b0;
          expect_out("stall", d, idx < P, idx == P + 4, 1'b1, 1'b0);
          next_cycle();
          drive_fields(rand_msg());
        end
        EN = 1'b1;
      end
      expect_out(idx < P ? "pre" : "data", d, idx < P, idx == P + 4, 1'b1, 1'b0);
      next_cycle();
      drive_fields(rand_msg());
    end
    msg_valid = 1'b0;
    exp_seq = exp_seq + 32'd1;
  endtask

  initial begin
    tmsg_t m0;
    reset_n = 1'b0;
    EN = 1'b1;
    msg_valid = 1'b1;
    drive_fields(rand_msg());
    expect_out("reset0", 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    expect_out("reset1", 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    reset_n = 1'b1;
    msg_valid = 1'b0;

    m0.action = 2'd0; m0.entry_type = 2'd0; m0.security_id = 32'h7B; m0.price = 64'd9;
    m0.quantity = 16'hAE; m0.num_orders = 8'd1; m0.price_level = 8'd1;
    run_frame(m0, -1, 0, -1);
    run_frame(rand_msg(), -1, 0, -1);
    run_frame(rand_msg(), P + 1, 3, -1);

    // EN low must block acceptance even with a valid record offered.
    EN = 1'b0;
    msg_valid = 1'b1;
    drive_fields(rand_msg());
    expect_out("en_block", 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    expect_out("en_block2", 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();

    run_frame(rand_msg(), -1, 0, 3);
    run_frame(rand_msg(), -1, 0, -1);

`ifdef MDP3_TX_SEQNUM_EN
    force dut.seq_num_q = 32'hFFFF_FFFF;
    next_cycle();
    release dut.seq_num_q;
    exp_seq = 32'hFFFF_FFFF;
    run_frame(rand_msg(), -1, 0, -1);
    run_frame(rand_msg(), -1, 0, -1);
`endif

    for (int r = 0; r < 8; r++) begin
      int sa;
      sa = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, P + 4));
      run_frame(rand_msg(), sa, int'($urandom_range(1, 3)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
